// File: rtl/lpr_pkg.sv
// Shared types and constants for the plate-boundary overlay controller.
package lpr_pkg;

   localparam int COORD_W  = 12;

   // Fixed-point thirds: x*85>>8 ~ x/3, x*171>>8 ~ 2x/3.
   localparam int THIRD1   = 85;
   localparam int THIRD2   = 171;
   localparam int THIRD_SH = 8;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      SHOW  = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/lpr_box_divider.sv
// Combinational centre / thirds lines for a box; results always lie inside the box.
module lpr_box_divider
   import lpr_pkg::*;
#(
   parameter int W = lpr_pkg::COORD_W
) (
   input  logic [W-1:0] hl_i,
   input  logic [W-1:0] hr_i,
   input  logic [W-1:0] vl_i,
   input  logic [W-1:0] vr_i,
   output logic [W-1:0] h2_o,
   output logic [W-1:0] v3_o,
   output logic [W-1:0] v5_o
);

   logic [W-1:0] dh, dv;
   logic [W+7:0] p3, p5, s3, s5;

   assign dh = hr_i - hl_i;
   assign dv = vr_i - vl_i;
   assign p3 = {8'd0, dv} * (W+8)'(THIRD1);
   assign p5 = {8'd0, dv} * (W+8)'(THIRD2);
   assign s3 = p3 >> THIRD_SH;
   assign s5 = p5 >> THIRD_SH;

   assign h2_o = hl_i + (dh >> 1);
   assign v3_o = vl_i + s3[W-1:0];
   assign v5_o = vl_i + s5[W-1:0];

endmodule

// File: rtl/lpr_box_ctrl.sv
// Plate-box overlay controller: validates candidates, buffers one pending box,
// commits it at frame start, and holds a stale box for HOLD_FRAMES frames.
module lpr_box_ctrl
   import lpr_pkg::*;
#(
   parameter int   COORD_W     = lpr_pkg::COORD_W,
   parameter int   H_ACT       = 1920,
   parameter int   V_ACT       = 1080,
   parameter int   HOLD_FRAMES = 8,
   parameter logic VS_POL      = 1'b1
) (
   input  logic               pixelclk,
   input  logic               reset_n,
   input  logic               en,
   input  logic               i_vsync,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [COORD_W-1:0] s_hl,
   input  logic [COORD_W-1:0] s_hr,
   input  logic [COORD_W-1:0] s_vl,
   input  logic [COORD_W-1:0] s_vr,
   output logic [COORD_W-1:0] hcount_l,
   output logic [COORD_W-1:0] hcount_r,
   output logic [COORD_W-1:0] vcount_l,
   output logic [COORD_W-1:0] vcount_r,
   output logic [COORD_W-1:0] h2,
   output logic [COORD_W-1:0] v3,
   output logic [COORD_W-1:0] v5,
   output logic               box_active,
   output logic [7:0]         rej_cnt
);

   localparam int MW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

   state_t             state_q, state_d;
   logic               vs_q;
   logic               fs, acc, cand_ok;
   logic [MW-1:0]      miss_q, miss_d;
   logic [7:0]         rej_q, rej_d;
   logic               pend_v_q, pend_v_d;
   logic [COORD_W-1:0] p_hl_q, p_hr_q, p_vl_q, p_vr_q;
   logic [COORD_W-1:0] p_hl_d, p_hr_d, p_vl_d, p_vr_d;
   logic [COORD_W-1:0] hl_q, hr_q, vl_q, vr_q, h2_q, v3_q, v5_q;
   logic [COORD_W-1:0] hl_d, hr_d, vl_d, vr_d, h2_d, v3_d, v5_d;
   logic [COORD_W-1:0] dv_h2, dv_v3, dv_v5;

   assign fs      = (i_vsync == VS_POL) && (vs_q != VS_POL);
   assign s_ready = en && !fs;
   assign acc     = s_valid && s_ready;
   assign cand_ok = (s_hl < s_hr) && (s_vl < s_vr)
                 && ({1'b0, s_hr} < (COORD_W+1)'(H_ACT))
                 && ({1'b0, s_vr} < (COORD_W+1)'(V_ACT));

   // Division lines are derived from the pending box so they land with it at commit.
   lpr_box_divider #(.W(COORD_W)) u_div (
      .hl_i (p_hl_q), .hr_i (p_hr_q), .vl_i (p_vl_q), .vr_i (p_vr_q),
      .h2_o (dv_h2),  .v3_o (dv_v3),  .v5_o (dv_v5)
   );

   // Next-state: enable override, frame-start commit/hold/blank, else candidate intake.
   always_comb begin
      state_d  = state_q;
      miss_d   = miss_q;
      rej_d    = rej_q;
      pend_v_d = pend_v_q;
      p_hl_d = p_hl_q; p_hr_d = p_hr_q; p_vl_d = p_vl_q; p_vr_d = p_vr_q;
      hl_d = hl_q; hr_d = hr_q; vl_d = vl_q; vr_d = vr_q;
      h2_d = h2_q; v3_d = v3_q; v5_d = v5_q;
      if (!en) begin
         state_d  = EMPTY;
         miss_d   = '0;
         pend_v_d = 1'b0;
         hl_d = '0; hr_d = '0; vl_d = '0; vr_d = '0;
         h2_d = '0; v3_d = '0; v5_d = '0;
      end else if (fs) begin
         if (pend_v_q) begin
            hl_d = p_hl_q; hr_d = p_hr_q; vl_d = p_vl_q; vr_d = p_vr_q;
            h2_d = dv_h2;  v3_d = dv_v3;  v5_d = dv_v5;
            state_d  = SHOW;
            miss_d   = '0;
            pend_v_d = 1'b0;
         end else if (state_q != EMPTY) begin
            if (miss_q == MW'(HOLD_FRAMES)) begin
               hl_d = '0; hr_d = '0; vl_d = '0; vr_d = '0;
               h2_d = '0; v3_d = '0; v5_d = '0;
               state_d = EMPTY;
            end else begin
               miss_d  = miss_q + 1'b1;
               state_d = HOLD;
            end
         end
      end else if (acc) begin
         if (cand_ok) begin
            p_hl_d = s_hl; p_hr_d = s_hr; p_vl_d = s_vl; p_vr_d = s_vr;
            pend_v_d = 1'b1;
         end else if (rej_q != 8'hFF) begin
            rej_d = rej_q + 8'd1;
         end
      end
   end

   // State and datapath registers; vsync history resets to the inactive level.
   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         vs_q     <= ~VS_POL;
         state_q  <= EMPTY;
         miss_q   <= '0;
         rej_q    <= '0;
         pend_v_q <= 1'b0;
         p_hl_q <= '0; p_hr_q <= '0; p_vl_q <= '0; p_vr_q <= '0;
         hl_q <= '0; hr_q <= '0; vl_q <= '0; vr_q <= '0;
         h2_q <= '0; v3_q <= '0; v5_q <= '0;
      end else begin
         vs_q     <= i_vsync;
         state_q  <= state_d;
         miss_q   <= miss_d;
         rej_q    <= rej_d;
         pend_v_q <= pend_v_d;
         p_hl_q <= p_hl_d; p_hr_q <= p_hr_d; p_vl_q <= p_vl_d; p_vr_q <= p_vr_d;
         hl_q <= hl_d; hr_q <= hr_d; vl_q <= vl_d; vr_q <= vr_d;
         h2_q <= h2_d; v3_q <= v3_d; v5_q <= v5_d;
      end
   end

   assign hcount_l   = hl_q;
   assign hcount_r   = hr_q;
   assign vcount_l   = vl_q;
   assign vcount_r   = vr_q;
   assign h2         = h2_q;
   assign v3         = v3_q;
   assign v5         = v5_q;
   assign box_active = (state_q != EMPTY);
   assign rej_cnt    = rej_q;

endmodule

// File: tb/tb_lpr_box_ctrl.sv
// Bench for lpr_box_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a frame-level behavioural model.
module tb_lpr_box_ctrl;

   localparam int HOLD = 2;

   logic        pixelclk = 0;
   logic        reset_n, en, i_vsync, s_valid, s_ready;
   logic [11:0] s_hl, s_hr, s_vl, s_vr;
   logic [11:0] hcount_l, hcount_r, vcount_l, vcount_r, h2, v3, v5;
   logic        box_active;
   logic [7:0]  rej_cnt;

   int checks = 0;
   int fails  = 0;
   bit cmp_en = 0;

   lpr_box_ctrl #(.COORD_W(12), .H_ACT(1920), .V_ACT(1080), .HOLD_FRAMES(HOLD), .VS_POL(1'b1)) dut (
      .pixelclk(pixelclk), .reset_n(reset_n), .en(en), .i_vsync(i_vsync),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_hl(s_hl), .s_hr(s_hr), .s_vl(s_vl), .s_vr(s_vr),
      .hcount_l(hcount_l), .hcount_r(hcount_r), .vcount_l(vcount_l), .vcount_r(vcount_r),
      .h2(h2), .v3(v3), .v5(v5), .box_active(box_active), .rej_cnt(rej_cnt)
   );

   always #5 pixelclk = ~pixelclk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int  m_pend_hl, m_pend_hr, m_pend_vl, m_pend_vr;
   bit  m_pend;
   int  m_hl, m_hr, m_vl, m_vr;  // displayed box (all 0 when blank)
   bit  m_show;
   int  m_missed;                // frames since last fresh box
   int  m_rej;
   bit  m_vs;

   always @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         m_pend = 0; m_show = 0; m_missed = 0; m_rej = 0; m_vs = 0;
         m_hl = 0; m_hr = 0; m_vl = 0; m_vr = 0;
      end else begin
         bit frame_start;
         frame_start = i_vsync && !m_vs;
         if (!en) begin
            m_pend = 0; m_show = 0; m_missed = 0;
            m_hl = 0; m_hr = 0; m_vl = 0; m_vr = 0;
         end else if (frame_start) begin
            if (m_pend) begin
               m_hl = m_pend_hl; m_hr = m_pend_hr; m_vl = m_pend_vl; m_vr = m_pend_vr;
               m_show = 1; m_missed = 0; m_pend = 0;
            end else if (m_show) begin
               if (m_missed >= HOLD) begin
                  m_show = 0; m_hl = 0; m_hr = 0; m_vl = 0; m_vr = 0;
               end else m_missed++;
            end
         end else if (s_valid) begin
            if (s_hl < s_hr && s_vl < s_vr && s_hr < 1920 && s_vr < 1080) begin
               m_pend = 1;
               m_pend_hl = s_hl; m_pend_hr = s_hr; m_pend_vl = s_vl; m_pend_vr = s_vr;
            end else if (m_rej < 255) m_rej++;
         end
         m_vs = i_vsync;
      end
   end

   // Compare DUT against model on the falling edge.
   always @(negedge pixelclk) begin
      if (reset_n && cmp_en) begin
         chk("s_ready",    s_ready,    (en && !(i_vsync && !m_vs)) ? 1 : 0);
         chk("hcount_l",   hcount_l,   m_hl);
         chk("hcount_r",   hcount_r,   m_hr);
         chk("vcount_l",   vcount_l,   m_vl);
         chk("vcount_r",   vcount_r,   m_vr);
         chk("h2",         h2,         (m_hl + m_hr) / 2);
         chk("v3",         v3,         m_vl + ((m_vr - m_vl) * 85) / 256);
         chk("v5",         v5,         m_vl + ((m_vr - m_vl) * 171) / 256);
         chk("box_active", box_active, m_show ? 1 : 0);
         chk("rej_cnt",    rej_cnt,    m_rej);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge pixelclk);
      #1;
   endtask

   task automatic send_box(input int hl, input int hr, input int vl, input int vr);
      int n;
      s_hl = 12'(hl); s_hr = 12'(hr); s_vl = 12'(vl); s_vr = 12'(vr);
      s_valid = 1;
      n = 0;
      #1;
      while (!s_ready && n < 20) begin
         tick(); #1; n++;
      end
      if (n >= 20) chk("send_timeout", 0, 1);
      @(posedge pixelclk); #1;
      s_valid = 0;
   endtask

   task automatic pulse();
      i_vsync = 0;
      repeat (3) tick();
      i_vsync = 1;
      tick();
   endtask

   task automatic rand_box();
      int hl, vl;
      if ($urandom % 10 < 7) begin
         hl = $urandom % 1800; vl = $urandom % 1000;
         s_hl = 12'(hl); s_vl = 12'(vl);
         s_hr = ($urandom % 8 == 0) ? 12'd1919 : 12'(hl + 1 + $urandom % (1919 - hl));
         s_vr = ($urandom % 8 == 0) ? 12'd1079 : 12'(vl + 1 + $urandom % (1079 - vl));
      end else begin
         s_hl = 12'($urandom); s_hr = 12'($urandom);
         s_vl = 12'($urandom); s_vr = 12'($urandom);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int en_lo;
      bit acc;
      reset_n = 0; en = 1; i_vsync = 0; s_valid = 0;
      s_hl = 0; s_hr = 0; s_vl = 0; s_vr = 0;
      #12;
      chk("rst_hcount_l", hcount_l, 0);
      chk("rst_box_active", box_active, 0);
      chk("rst_rej_cnt", rej_cnt, 0);
      @(posedge pixelclk); #1;
      reset_n = 1;
      cmp_en = 1;
      tick();

      // Single box, committed only at frame start.
      send_box(100, 300, 50, 120);
      tick();
      chk("pre_vs_hcount_l", hcount_l, 0);
      chk("pre_vs_active", box_active, 0);
      pulse();
      chk("t1_hcount_l", hcount_l, 100);
      chk("t1_hcount_r", hcount_r, 300);
      chk("t1_vcount_l", vcount_l, 50);
      chk("t1_vcount_r", vcount_r, 120);
      chk("t1_h2", h2, 200);
      chk("t1_v3", v3, 73);
      chk("t1_v5", v5, 96);
      chk("t1_active", box_active, 1);

      // Newest pending box wins.
      i_vsync = 0; tick();
      send_box(10, 20, 10, 20);
      send_box(30, 60, 40, 70);
      pulse();
      chk("t2_hcount_l", hcount_l, 30);
      chk("t2_vcount_r", vcount_r, 70);
      chk("t2_h2", h2, 45);

      // Rejections, then saturation.
      i_vsync = 0; tick();
      send_box(300, 100, 0, 10);
      send_box(0, 1920, 0, 10);
      chk("t3_rej2", rej_cnt, 2);
      chk("t3_hold_l", hcount_l, 30);
      for (int i = 0; i < 300; i++) send_box(300, 100, 0, 10);
      chk("t3_rej_sat", rej_cnt, 255);

      // Hold for two missed frames, blank on the third.
      pulse();
      chk("t4_f1_active", box_active, 1);
      chk("t4_f1_l", hcount_l, 30);
      pulse();
      chk("t4_f2_active", box_active, 1);
      pulse();
      chk("t4_f3_active", box_active, 0);
      chk("t4_f3_l", hcount_l, 0);

      // Candidate presented on the frame-start cycle is taken one cycle later.
      i_vsync = 0; repeat (2) tick();
      s_hl = 5; s_hr = 15; s_vl = 5; s_vr = 15; s_valid = 1; i_vsync = 1;
      #1;
      chk("t5_ready_fs", s_ready, 0);
      tick();
      chk("t5_ready_after", s_ready, 1);
      tick();
      s_valid = 0;
      chk("t5_not_yet", box_active, 0);
      pulse();
      chk("t5_commit_l", hcount_l, 5);
      chk("t5_commit_act", box_active, 1);

      // Asynchronous reset mid-frame.
      #2; reset_n = 0; #1;
      chk("t6_rst_l", hcount_l, 0);
      chk("t6_rst_act", box_active, 0);
      tick(); tick();
      reset_n = 1; i_vsync = 0;
      tick();
      send_box(200, 400, 100, 400);
      pulse();
      chk("t6_recommit", hcount_l, 200);
      en = 0; #1;
      chk("t6_en_ready", s_ready, 0);
      tick();
      chk("t6_en_blank", box_active, 0);
      chk("t6_en_l", hcount_l, 0);
      en = 1; i_vsync = 0; tick();

      // Randomized frames.
      en_lo = 0; acc = 0;
      for (int f = 0; f < 60; f++) begin
         int len;
         bit quiet;
         len = 30 + $urandom % 30;
         quiet = ($urandom % 2) == 1;
         for (int c = 0; c < len; c++) begin
            i_vsync = (c < 3);
            if (en_lo == 0 && $urandom % 150 == 0) en_lo = 2 + $urandom % 5;
            en = (en_lo == 0);
            if (en_lo > 0) en_lo--;
            if (!s_valid || acc) begin
               s_valid = !quiet && ($urandom % 4 == 0);
               rand_box();
            end
            #1;
            acc = s_valid && s_ready;
            tick();
         end
      end
      s_valid = 0; en = 1; i_vsync = 0;
      repeat (3) tick();
      cmp_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
